front_pipe_regs: RTL
====================

# front_pipe_regs

Front-end pipeline register bank of the 5-stage MIPS core. It holds the PC register, the IF/ID register and the ID/EX register, and obeys the stall, flush and branch-clear commands issued by the hazard unit. It also keeps saturating stall and flush counters, plus a sticky stuck-stall flag for debug and verification. It sits between the fetch logic, the decoder/register file and the execute stage.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, instruction, operand and immediate fields
- REG_ADDR_WIDTH, 5, width of Rs/Rt/Rd fields
- CTRL_WIDTH, 10, width of the packed decode control bundle (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst)
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_WIDTH, 16, width of the performance counters
- STALL_LIMIT, 64, consecutive StallF cycles that set StuckErr

Ports:
- CLK  in  1  core clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- PCNextF  in  DATA_WIDTH  next PC from the fetch mux
- InstrF  in  DATA_WIDTH  instruction memory read data
- PCPlus4F  in  DATA_WIDTH  PCF+4
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlushE  in  1  bubble ID/EX
- PCSrcD  in  1  branch taken in decode; clears IF/ID
- JumpD  in  1  jump in decode; clears IF/ID
- CtrlD  in  CTRL_WIDTH  decode control bundle
- RD1D, RD2D  in  DATA_WIDTH each  register file read data
- RsD, RtD, RdD  in  REG_ADDR_WIDTH each  register fields
- SignImmD  in  DATA_WIDTH  sign-extended immediate
- PCF  out  DATA_WIDTH  fetch PC
- InstrD, PCPlus4D  out  DATA_WIDTH each  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- CtrlE  out  CTRL_WIDTH; RD1E, RD2E, SignImmE  out  DATA_WIDTH; RsE, RtE, RdE  out  REG_ADDR_WIDTH  ID/EX contents
- ValidE  out  1  ID/EX holds a real instruction
- StallCount, FlushCount  out  CNT_WIDTH  saturating counters
- StuckErr  out  1  sticky stuck-stall flag

## Operation
- Reset values:
  - PCF = RESET_PC.
  - Every other output = 0, including ValidD and ValidE.
- PC register:
  - StallF=1: PCF holds.
  - Otherwise: PCF <= PCNextF.
- IF/ID register, with clr = PCSrcD | JumpD. Priority order:
  1. StallD=1: hold all fields. Stall beats clear.
  2. clr=1: InstrD=0 (nop), PCPlus4D=0, ValidD=0.
  3. Otherwise: load InstrF and PCPlus4F, ValidD=1.
- ID/EX register:
  - FlushE=1: all fields 0, ValidE=0. A zero CtrlE means no RegWrite and no MemWrite.
  - Otherwise: load all D-stage fields, ValidE <= ValidD.
  - ID/EX never stalls.
- StallCount: +1 on every cycle StallF=1; saturates at all-ones.
- FlushCount: +1 on every cycle FlushE=1; saturates at all-ones.
- StuckErr:
  - An internal run counter counts consecutive StallF=1 cycles and clears on any StallF=0 cycle. It saturates at STALL_LIMIT.
  - StuckErr sets when the run counter reaches STALL_LIMIT.
  - It stays set until RST.
- Counter widths: run counter is clog2(STALL_LIMIT+1) bits. No arithmetic wraps.

## Timing
- All outputs are registered; each updates one cycle after the inputs sampled at the edge.
- No combinational input-to-output path exists.
- Fetch-to-decode latency: 1 cycle. Decode-to-execute latency: 1 cycle.
- Stall-cycle behaviour:
  - Load-use stall (StallF=StallD=FlushE=1 in the same cycle): PCF and IF/ID hold and ID/EX receives a bubble. Next cycle, the held instruction enters ID/EX once the stall drops.
  - PCSrcD=1 with StallD=0: IF/ID is a bubble on the next edge, and PCF <= PCNextF (the branch target).
  - PCSrcD=1 with StallD=1 (branch stall): IF/ID holds. The branch re-evaluates next cycle.
- RST mid-operation overrides everything on that edge. All counters and StuckErr clear, and PCF = RESET_PC on the following cycle.
- StuckErr asserts at the edge that completes the STALL_LIMIT-th consecutive stall cycle.

## Test plan
- Reset then free-run, RESET_PC=0, PCNextF=PCF+4, no hazards -> PCF = 0,4,8,...; InstrD follows InstrF by 1 cycle; ValidD=1 from the 2nd cycle; ValidE=1 from the 3rd.
- One-cycle load-use stall (StallF=StallD=FlushE=1) at PCF=0x10 -> PCF stays 0x10 for 2 cycles; ValidE=0 for 1 cycle; StallCount=1; FlushCount=1.
- Taken branch, PCSrcD=1, StallD=0, PCNextF=0x40 -> next PCF=0x40; InstrD=0; ValidD=0; then the instruction at 0x40 decodes.
- PCSrcD=1 with StallD=1 for 1 cycle, then StallD=0 -> IF/ID holds one cycle, then clears; no instruction is lost or duplicated.
- STALL_LIMIT=4, StallF=1 for 3 cycles, one cycle of 0, then 4 cycles of 1 -> StuckErr=0 after the 3-cycle run; StuckErr=1 after the 4th cycle of the second run; stays 1 until RST.
- CNT_WIDTH=4, FlushE held for 20 cycles -> FlushCount saturates at 15. RST mid-run -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/front_pipe_regs.sv
// front_pipe_regs: PC, IF/ID and ID/EX registers with hazard controls, saturating stall/flush counters and stuck-stall flag
module front_pipe_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_WIDTH = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     PCNextF,
  input  logic [DATA_WIDTH-1:0]     InstrF,
  input  logic [DATA_WIDTH-1:0]     PCPlus4F,
  input  logic                      StallF,
  input  logic                      StallD,
  input  logic                      FlushE,
  input  logic                      PCSrcD,
  input  logic                      JumpD,
  input  logic [CTRL_WIDTH-1:0]     CtrlD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [REG_ADDR_WIDTH-1:0] RsD,
  input  logic [REG_ADDR_WIDTH-1:0] RtD,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [DATA_WIDTH-1:0]     SignImmD,
  output logic [DATA_WIDTH-1:0]     PCF,
  output logic [DATA_WIDTH-1:0]     InstrD,
  output logic [DATA_WIDTH-1:0]     PCPlus4D,
  output logic                      ValidD,
  output logic [CTRL_WIDTH-1:0]     CtrlE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     SignImmE,
  output logic [REG_ADDR_WIDTH-1:0] RsE,
  output logic [REG_ADDR_WIDTH-1:0] RtE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidE,
  output logic [CNT_WIDTH-1:0]      StallCount,
  output logic [CNT_WIDTH-1:0]      FlushCount,
  output logic                      StuckErr
);
  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STALL_LIMIT);
  logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic valid_d_q, valid_d_d, valid_e_q, valid_e_d, stuck_q, stuck_d, clr;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [RW-1:0] run_q, run_d;
  always_comb begin
    clr = PCSrcD | JumpD;
    pc_d = StallF ? pc_q : PCNextF;
    // stall outranks the branch/jump clear so a stalled branch keeps its slot
    instr_d = StallD ? instr_q : clr ? '0 : InstrF;
    pcp4_d = StallD ? pcp4_q : clr ? '0 : PCPlus4F;
    valid_d_d = StallD ? valid_d_q : !clr;
    ctrl_d = FlushE ? '0 : CtrlD;
    rd1_d = FlushE ? '0 : RD1D;
    rd2_d = FlushE ? '0 : RD2D;
    imm_d = FlushE ? '0 : SignImmD;
    rs_d = FlushE ? '0 : RsD;
    rt_d = FlushE ? '0 : RtD;
    rd_d = FlushE ? '0 : RdD;
    valid_e_d = FlushE ? 1'b0 : valid_d_q;
    stall_cnt_d = (StallF && stall_cnt_q != '1) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
    flush_cnt_d = (FlushE && flush_cnt_q != '1) ? flush_cnt_q + CNT_WIDTH'(1) : flush_cnt_q;
    run_d = !StallF ? '0 : (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
    stuck_d = stuck_q | (run_d == RUN_MAX);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= RESET_PC;
      instr_q <= '0;
      pcp4_q <= '0;
      valid_d_q <= 1'b0;
      ctrl_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      valid_e_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_q <= '0;
      stuck_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      pcp4_q <= pcp4_d;
      valid_d_q <= valid_d_d;
      ctrl_q <= ctrl_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      imm_q <= imm_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      rd_q <= rd_d;
      valid_e_q <= valid_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_q <= run_d;
      stuck_q <= stuck_d;
    end
  end
  assign PCF = pc_q;
  assign InstrD = instr_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD = valid_d_q;
  assign CtrlE = ctrl_q;
  assign RD1E = rd1_q;
  assign RD2E = rd2_q;
  assign SignImmE = imm_q;
  assign RsE = rs_q;
  assign RtE = rt_q;
  assign RdE = rd_q;
  assign ValidE = valid_e_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
  assign StuckErr = stuck_q;
endmodule
